controlador_multiplicador: RTL and testbench
============================================

// Module: controlador_multiplicador
// PURPOSE
//  Sequential shift-and-add multiplier for unsigned LARGURA-bit operands.
//  Produces the same product as the combinational array multiplier, one partial-product row per clock.
//  An FSM sequences a single (LARGURA+1)-bit adder over LARGURA cycles.
//  Driven by a start/busy/done handshake. The product drives the board LEDs.
// PARAMETERS
//  LARGURA  5  operand width in bits; product is 2*LARGURA bits
// PORTS
//  CLOCK_50  in   1          system clock, rising edge
//  RESET_N   in   1          asynchronous, active-low reset
//  inicio    in   1          start request, sampled only in IDLE
//  a         in   LARGURA    multiplicand, unsigned
//  b         in   LARGURA    multiplier, unsigned
//  ocupado   out  1          high while CALC (busy)
//  feito     out  1          one-cycle done pulse (FEITO state)
//  produto   out  2*LARGURA  result register, held until next completion
// BEHAVIOUR
//  Clocking/reset: one clock (CLOCK_50). RESET_N is asynchronous and active-low.
//  Reset (RESET_N=0, async): state=IDLE, P=0, A_r=0, cnt=0, produto=0, ocupado=0, feito=0.
//  Registers:
//   - A_r[LARGURA-1:0]
//   - P[2*LARGURA-1:0]
//   - cnt, $clog2(LARGURA+1) bits
//   - produto[2*LARGURA-1:0]
//  States: IDLE -> CALC -> FEITO -> IDLE.
//  IDLE: ocupado=0, feito=0. On an edge with inicio=1:
//   - A_r<=a, P<={LARGURA'b0,b}, cnt<=0, go CALC.
//   - With inicio=0: stay in IDLE.
//  CALC: ocupado=1. Each edge performs one iteration:
//   - soma[LARGURA:0] = P[2L-1:L] + (P[0] ? A_r : 0)   (L=LARGURA, zero-extended add)
//   - P <= {soma, P[L-1:1]}   (2L bits total; shift right by one)
//   - cnt <= cnt+1
//   - On the edge where cnt==LARGURA-1: also produto <= next P value, go FEITO.
//  FEITO: feito=1, ocupado=0 for exactly one cycle; next edge -> IDLE unconditionally.
//  Latency: start edge E0; iterations on E1..EL; feito high between EL and EL+1.
//   - Start-to-done is LARGURA cycles. Back-to-back throughput is one result per LARGURA+2 cycles.
//  Latency is fixed: no early exit for zero operands or all-zero remaining bits.
//  Operand capture: a/b are sampled only at the accepting edge; later changes have no effect.
//  inicio is ignored in CALC and FEITO. It is not queued and has no error indication.
//   - inicio held high continuously restarts on the first IDLE edge after FEITO.
//  produto: changes only at the final CALC edge (or reset).
//   - Holds the previous result during a new computation.
//  Arithmetic: unsigned; the maximum (2^L-1)^2 fits 2L bits, so no overflow is possible.
//   - The soma carry bit is always retained in P.
//  Reset mid-operation: computation aborted, all registers to reset values.
//   - No feito pulse is generated for the aborted operation.
//  Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
// TESTING (LARGURA=5)
//  1. 31x31: inicio pulse with a=31, b=31 -> ocupado high 5 cycles, feito pulse in 6th cycle, produto=961.
//  2. a=0, b=17 and a=19, b=0 -> produto=0 each.
//     - Check latency is still 5 cycles; check produto held until the next feito.
//  3. Start a=3, b=5, then change a/b and pulse inicio during CALC and FEITO.
//     - Expect produto=15, exactly one feito, state returns to IDLE.
//  4. inicio held high for 3 ops: (7,9), (12,11), (31,1).
//     - Expect feito every 7 cycles; produto=63, 132, 31 in order.
//  5. Assert RESET_N=0 asynchronously mid-CALC (cycle 3 of a 21x13 op).
//     - Outputs are 0 immediately, no feito; a new op (21,13) gives 273.
//  6. Exhaustive: all 1024 a/b pairs back-to-back vs reference model a*b; zero mismatches.

Source files
------------

// File: rtl/controlador_multiplicador.sv
// controlador_multiplicador
//   Sequential shift-and-add multiplier for unsigned LARGURA-bit operands.
//   One (LARGURA+1)-bit adder is reused for LARGURA cycles. Each cycle adds
//   one partial-product row and shifts the accumulator right by one bit.
//   A start/busy/done handshake sequences the operation.
//
// Ports
//   CLOCK_50  in   1          system clock, rising edge
//   RESET_N   in   1          asynchronous active-low reset
//   inicio    in   1          start request; sampled only in IDLE
//   a         in   LARGURA    multiplicand (unsigned)
//   b         in   LARGURA    multiplier (unsigned)
//   ocupado   out  1          high while the iterations run
//   feito     out  1          one-cycle done pulse
//   produto   out  2*LARGURA  last completed product; held until the next completion
module controlador_multiplicador #(
    parameter int LARGURA = 5
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_N,
    input  logic                   inicio,
    input  logic [LARGURA-1:0]     a,
    input  logic [LARGURA-1:0]     b,
    output logic                   ocupado,
    output logic                   feito,
    output logic [2*LARGURA-1:0]   produto
);

    localparam int CW = $clog2(LARGURA + 1);

    typedef enum logic [1:0] {IDLE, CALC, FEITO} estado_t;

    estado_t              estado;
    logic [LARGURA-1:0]   a_r;
    logic [2*LARGURA-1:0] p;
    logic [2*LARGURA-1:0] p_prox;
    logic [CW-1:0]        cnt;
    logic [LARGURA:0]     soma;

    // P holds the partial sum in its upper half and the unconsumed multiplier
    // bits in its lower half. p[0] is the current multiplier bit. The carry of
    // the add lands in bit 2L-1 after the shift, so no bit is ever lost.
    always_comb begin
        soma   = {1'b0, p[2*LARGURA-1:LARGURA]} + (p[0] ? {1'b0, a_r} : '0);
        p_prox = {soma, p[LARGURA-1:1]};
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            estado  <= IDLE;
            a_r     <= '0;
            p       <= '0;
            cnt     <= '0;
            produto <= '0;
            ocupado <= 1'b0;
            feito   <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (inicio) begin
                        a_r     <= a;
                        p       <= {{LARGURA{1'b0}}, b};
                        cnt     <= '0;
                        estado  <= CALC;
                        ocupado <= 1'b1;
                    end
                end
                CALC: begin
                    p   <= p_prox;
                    cnt <= cnt + 1'b1;
                    // The last row is in p_prox, so publish it directly.
                    if (cnt == CW'(LARGURA - 1)) begin
                        produto <= p_prox;
                        estado  <= FEITO;
                        ocupado <= 1'b0;
                        feito   <= 1'b1;
                    end
                end
                FEITO: begin
                    feito  <= 1'b0;
                    estado <= IDLE;
                end
                default: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                    feito   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_multiplicador.sv
module tb_controlador_multiplicador;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inicio;
    logic [4:0] a, b;
    logic       ocupado, feito;
    logic [9:0] produto;

    int nvec = 0;
    int nerr = 0;
    int last = 0;           // value produto must hold until the next feito

    int qa[$], qb[$], qe[$];

    controlador_multiplicador #(.LARGURA(5)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .inicio   (inicio),
        .a        (a),
        .b        (b),
        .ocupado  (ocupado),
        .feito    (feito),
        .produto  (produto)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation from IDLE: checks busy length, latency, hold and result.
    task automatic op(input logic [4:0] x, input logic [4:0] y, input int exp, input string tag);
        int n = 0, busy = 0;
        @(negedge clk); a = x; b = y; inicio = 1'b1;
        @(negedge clk); inicio = 1'b0;
        while (!feito && n < 20) begin
            if (ocupado) busy++;
            chk({tag, "_hold"}, int'(produto), last);
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, n, 5);
        chk({tag, "_busy"}, busy, 5);
        chk({tag, "_feito"}, int'(feito), 1);
        chk({tag, "_ocup_done"}, int'(ocupado), 0);
        chk({tag, "_prod"}, int'(produto), exp);
        last = exp;
        @(negedge clk);
        chk({tag, "_pulse"}, int'(feito), 0);
    endtask

    // Back-to-back operations with inicio held high; operands in qa/qb, results in qe.
    task automatic stream(input string tag);
        int idx = 0, t_last = 0, cyc = 0;
        int n = qa.size();
        @(negedge clk); a = 5'(qa[0]); b = 5'(qb[0]); inicio = 1'b1;
        while (idx < n && cyc < n * 7 + 20) begin
            @(negedge clk);
            cyc++;
            if (feito) begin
                chk({tag, "_prod"}, int'(produto), qe[idx]);
                if (idx > 0) chk({tag, "_per"}, cyc - t_last, 7);
                t_last = cyc;
                idx++;
                if (idx < n) begin
                    a = 5'(qa[idx]); b = 5'(qb[idx]);
                end else begin
                    inicio = 1'b0;
                end
            end
        end
        chk({tag, "_count"}, idx, n);
        last = qe[n-1];
        @(negedge clk);
    endtask

    initial begin
        int nf, nb;
        rst_n = 1'b0; inicio = 1'b0; a = '0; b = '0;
        #35;
        chk("rst_ocup", int'(ocupado), 0);
        chk("rst_feito", int'(feito), 0);
        chk("rst_prod", int'(produto), 0);
        @(negedge clk); rst_n = 1'b1;

        // 1: largest operands
        op(5'd31, 5'd31, 961, "t1_31x31");
        // 2: zero operands keep full latency; 961 held during the first
        op(5'd0, 5'd17, 0, "t2_0x17");
        op(5'd19, 5'd0, 0, "t2_19x0");

        // 3: operand changes and inicio pulses during CALC/FEITO are ignored
        @(negedge clk); a = 5'd3; b = 5'd5; inicio = 1'b1;
        @(negedge clk); inicio = 1'b0; a = 5'd31; b = 5'd31;
        @(negedge clk); inicio = 1'b1; a = 5'd7;
        @(negedge clk); inicio = 1'b0;
        nf = 0;
        for (int i = 0; i < 20 && !feito; i++) @(negedge clk);
        chk("t3_feito", int'(feito), 1);
        chk("t3_prod", int'(produto), 15);
        if (feito) nf++;
        inicio = 1'b1;                  // pulse during FEITO
        @(negedge clk); inicio = 1'b0;
        chk("t3_idle", int'(ocupado), 0);
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (feito) nf++;
            if (ocupado) nb++;
        end
        chk("t3_one_feito", nf, 1);
        chk("t3_no_restart", nb, 0);
        last = 15;

        // 4: inicio held high across three operations
        qa = '{7, 12, 31}; qb = '{9, 11, 1}; qe = '{63, 132, 31};
        stream("t4");

        // 5: asynchronous reset in the third CALC cycle of 21x13
        @(negedge clk); a = 5'd21; b = 5'd13; inicio = 1'b1;
        @(posedge clk);                 // E0
        @(negedge clk); inicio = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_ocup", int'(ocupado), 0);
        chk("t5_rst_feito", int'(feito), 0);
        chk("t5_rst_prod", int'(produto), 0);
        @(negedge clk); rst_n = 1'b1;
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (feito) nf++;
        end
        chk("t5_no_feito", nf, 0);
        last = 0;
        op(5'd21, 5'd13, 273, "t5_21x13");

        // 6: exhaustive, back-to-back, against a*b
        qa.delete(); qb.delete(); qe.delete();
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) begin
                qa.push_back(i); qb.push_back(j); qe.push_back(i * j);
            end
        stream("t6");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
